// File: rtl/arb_req_pkg.sv
// Shared constants and types for the three-channel arbiter request front end.
package arb_req_pkg;

  localparam int NUM_REQ         = 3;
  localparam int DEF_DW          = 8;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_GNT_TIMEOUT = 8;

  typedef logic [1:0] ch_id_t;

endpackage

// File: rtl/arb_req_fifo.sv
// Per-channel FIFO with registered count; head entry is read combinationally.
module arb_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_front.sv
// Buffers three request channels in front of an external round-robin arbiter.
// Optional grant watchdog: define ARB_REQ_TIMEOUT_EN.
module arb_req_front
  import arb_req_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      in_valid,
  input  logic [3*DW-1:0] in_data,
  output logic [2:0]      in_ready,
  output logic            req1,
  output logic            req2,
  output logic            req3,
  input  logic            gnt1,
  input  logic            gnt2,
  input  logic            gnt3,
  output logic            out_valid,
  output logic [1:0]      out_id,
  output logic [DW-1:0]   out_data,
  output logic            proto_err,
  output logic [2:0]      timeout_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GNT_TIMEOUT < 1) begin : g_bad_param
    $error("arb_req_front: illegal DEPTH or GNT_TIMEOUT");
  end

  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [CW-1:0]      cnt  [NUM_REQ];
  logic [DW-1:0]      head [NUM_REQ];
  logic               legal;
  logic               bad;
  ch_id_t             sel_id;
  logic [DW-1:0]      sel_data;

  assign gnt      = {gnt3, gnt2, gnt1};
  assign req      = ~empty;
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign {req3, req2, req1} = req;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_ch
    arb_req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push[k]),
      .pop    (pop[k]),
      .wdata  (in_data[k*DW +: DW]),
      .rdata  (head[k]),
      .count  (cnt[k]),
      .full   (full[k]),
      .empty  (empty[k])
    );

    always_ff @(posedge clk) begin
      if (resetn) assert (cnt[k] <= CW'(DEPTH));
    end
  end

  // Only a lone grant aimed at a requesting channel may pop.
  always_comb begin
    legal = $onehot(gnt) && |(gnt & req);
    bad   = |gnt && !legal;
    pop   = legal ? gnt : '0;
  end

  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    unique case (1'b1)
      pop[0]: begin sel_id = 2'd1; sel_data = head[0]; end
      pop[1]: begin sel_id = 2'd2; sel_data = head[1]; end
      pop[2]: begin sel_id = 2'd3; sel_data = head[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      proto_err <= 1'b0;
    end else begin
      out_valid <= |pop;
      out_id    <= sel_id;
      if (|pop) out_data <= sel_data;
      if (bad)  proto_err <= 1'b1;
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TW = $clog2(GNT_TIMEOUT + 1);

  logic [TW-1:0]      tcnt [NUM_REQ];
  logic [NUM_REQ-1:0] terr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_REQ; k++) tcnt[k] <= '0;
      terr <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req[k] && !gnt[k]) begin
          if (tcnt[k] != TW'(GNT_TIMEOUT)) tcnt[k] <= tcnt[k] + TW'(1);
          if (tcnt[k] == TW'(GNT_TIMEOUT - 1)) terr[k] <= 1'b1;
        end else begin
          tcnt[k] <= '0;
        end
      end
    end
  end

  assign timeout_err = terr;
`else
  assign timeout_err = 3'b000;
`endif

endmodule

// File: tb/tb_arb_req_front.sv
// Directed-vector bench for arb_req_front (DW=8, DEPTH=4, GNT_TIMEOUT=8).
module tb_arb_req_front;

  localparam int DW = 8;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam logic [2:0] TO_EXP = 3'b001;
`else
  localparam logic [2:0] TO_EXP = 3'b000;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [2:0]      in_valid = '0;
  logic [3*DW-1:0] in_data = '0;
  logic [2:0]      in_ready;
  logic            req1, req2, req3;
  logic            gnt1 = 1'b0;
  logic            gnt2 = 1'b0;
  logic            gnt3 = 1'b0;
  logic            out_valid;
  logic [1:0]      out_id;
  logic [DW-1:0]   out_data;
  logic            proto_err;
  logic [2:0]      timeout_err;
  logic [2:0]      reqv;

  int nvec = 0;
  int nerr = 0;

  assign reqv = {req3, req2, req1};

  always #5 clk = ~clk;

  arb_req_front #(
    .DW          (DW),
    .DEPTH       (4),
    .GNT_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .req1        (req1),
    .req2        (req2),
    .req3        (req3),
    .gnt1        (gnt1),
    .gnt2        (gnt2),
    .gnt3        (gnt3),
    .out_valid   (out_valid),
    .out_id      (out_id),
    .out_data    (out_data),
    .proto_err   (proto_err),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int ch, input logic [7:0] d);
    in_valid[ch-1] = 1'b1;
    in_data[(ch-1)*DW +: DW] = d;
    step();
    in_valid = '0;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] id, input logic [7:0] d);
    chk({tag, ".v"},  32'(out_valid), 32'(v));
    chk({tag, ".id"}, 32'(out_id),    32'(id));
    chk({tag, ".d"},  32'(out_data),  32'(d));
  endtask

  initial begin
    #12;
    chk("rst.ready", 32'(in_ready), 32'h7);
    chk("rst.req", 32'(reqv), 32'h0);
    chk_out("rst.out", 1'b0, 2'd0, 8'h00);
    chk("rst.perr", 32'(proto_err), 32'h0);
    chk("rst.terr", 32'(timeout_err), 32'h0);
    resetn = 1'b1;
    step();
    chk("post_rst.ready", 32'(in_ready), 32'h7);

    // single push then grant
    push1(1, 8'hA1);
    chk("t1.req", 32'(reqv), 32'h1);
    gnt1 = 1'b1;
    step();
    gnt1 = 1'b0;
    chk_out("t1.out", 1'b1, 2'd1, 8'hA1);
    chk("t1.req0", 32'(reqv), 32'h0);
    step();
    chk_out("t1.idle", 1'b0, 2'd0, 8'hA1);

    // fill ch2, overflow attempt, held grant drains in order
    for (int i = 0; i < 4; i++) push1(2, 8'hB0 + 8'(i));
    chk("t2.full", 32'(in_ready), 32'h5);
    push1(2, 8'hFF);
    chk("t2.still_full", 32'(in_ready), 32'h5);
    gnt2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("t2.pop%0d", i), 1'b1, 2'd2, 8'hB0 + 8'(i));
    end
    gnt2 = 1'b0;
    chk("t2.req0", 32'(reqv), 32'h0);
    chk("t2.perr", 32'(proto_err), 32'h0);

    // ch3 wrap with interleaved grants and a same-cycle push+pop
    push1(3, 8'd1);
    push1(3, 8'd2);
    push1(3, 8'd3);
    in_valid[2] = 1'b1;
    in_data[2*DW +: DW] = 8'd4;
    gnt3 = 1'b1;
    step();
    in_valid = '0;
    gnt3 = 1'b0;
    chk_out("t3.o1", 1'b1, 2'd3, 8'd1);
    chk("t3.rdy3", 32'(in_ready), 32'h7);
    push1(3, 8'd5);
    chk("t3.full", 32'(in_ready), 32'h3);
    gnt3 = 1'b1;
    step();
    gnt3 = 1'b0;
    chk_out("t3.o2", 1'b1, 2'd3, 8'd2);
    push1(3, 8'd6);
    chk("t3.full2", 32'(in_ready), 32'h3);
    gnt3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("t3.o%0d", i + 3), 1'b1, 2'd3, 8'(i + 3));
    end
    gnt3 = 1'b0;
    chk("t3.req0", 32'(reqv), 32'h0);

    // illegal grants
    in_valid = 3'b011;
    in_data = {8'h00, 8'h22, 8'h11};
    step();
    in_valid = '0;
    gnt1 = 1'b1;
    gnt2 = 1'b1;
    step();
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    chk("t4.nopop", 32'(out_valid), 32'h0);
    chk("t4.perr", 32'(proto_err), 32'h1);
    chk("t4.req", 32'(reqv), 32'h3);
    step();
    chk("t4.sticky", 32'(proto_err), 32'h1);
    resetn = 1'b0;
    #1;
    chk("t4.perr_rst", 32'(proto_err), 32'h0);
    resetn = 1'b1;
    step();
    gnt3 = 1'b1;
    step();
    gnt3 = 1'b0;
    chk("t4.gnt3_perr", 32'(proto_err), 32'h1);
    chk("t4.gnt3_nopop", 32'(out_valid), 32'h0);
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    step();

    // grant watchdog
    push1(1, 8'h55);
    for (int i = 0; i < 7; i++) step();
    chk("t5.pre", 32'(timeout_err), 32'h0);
    step();
    chk("t5.to", 32'(timeout_err), 32'(TO_EXP));
    gnt1 = 1'b1;
    step();
    gnt1 = 1'b0;
    chk_out("t5.out", 1'b1, 2'd1, 8'h55);
    chk("t5.sticky", 32'(timeout_err), 32'(TO_EXP));

    // reset with entries queued
    in_valid = 3'b111;
    in_data = {8'h33, 8'h22, 8'h11};
    step();
    in_valid = '0;
    push1(1, 8'h44);
    gnt1 = 1'b1;
    step();
    gnt1 = 1'b0;
    chk_out("t6.pre", 1'b1, 2'd1, 8'h11);
    resetn = 1'b0;
    #1;
    chk_out("t6.rst", 1'b0, 2'd0, 8'h00);
    chk("t6.req", 32'(reqv), 32'h0);
    chk("t6.ready", 32'(in_ready), 32'h7);
    chk("t6.terr", 32'(timeout_err), 32'h0);
    #10;
    resetn = 1'b1;
    chk("t6.ready_rel", 32'(in_ready), 32'h7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6.quiet%0d", i), 32'({reqv, out_valid}), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
